bit_serial_operand_tx: RTL and testbench

- Parallel-in, serial-out transmitter that feeds the bit-serial operand input of the serial large-number multiplier.
- Accepts one WIDTH-bit operand word via a valid/ready handshake and shifts it out one bit per accepted beat.
- Marks the frame with start/end flags and signals completion with a done pulse.
- Sits between the operand source (register file or bench) and the multiplier's serial input.

---
 rtl/bit_serial_operand_tx.sv | 222 ++++++++++++++++++++++
 tb/tb_bit_serial_operand_tx.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/bit_serial_operand_tx.sv
// bit_serial_operand_tx
//
// Parallel-in, serial-out transmitter feeding the bit-serial operand input of
// the serial large-number multiplier. One WIDTH-bit word is accepted over a
// valid/ready handshake and shifted out one bit per accepted beat, with
// first/last-bit flags and a one-cycle completion pulse.
//
// Parameters:
//   WIDTH      operand width in bits (>= 1)
//   MSB_FIRST  0: bit 0 goes out first; 1: bit WIDTH-1 goes out first
//
// Ports:
//   clk         system clock, rising edge
//   resetn      asynchronous reset, active HIGH despite the name
//   in_valid    operand word present on in_data
//   in_ready    transmitter can accept a word (IDLE only)
//   in_data     operand word
//   sout        serial data bit (0 when sout_valid is low)
//   sout_valid  sout carries a frame bit
//   sout_ready  downstream accepts the current bit
//   sof         current bit is the first bit of the frame
//   eof         current bit is the last bit of the frame
//   busy        frame in progress
//   done        one-cycle pulse after the last bit is accepted
//
// Optional feature (macro SERIAL_TX_PARITY_EN):
//   When defined, an even-parity bit (XOR of the latched word) is appended as
//   an extra beat after data bit WIDTH-1; eof then marks the parity beat.
//
// Every output is decoded from registered state (FSM, counter, shift
// register), so there is no combinational path from any input to any output.

module bit_serial_operand_tx #(
    parameter int unsigned WIDTH     = 256,
    parameter bit          MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             sout,
    output logic             sout_valid,
    input  logic             sout_ready,
    output logic             sof,
    output logic             eof,
    output logic             busy,
    output logic             done
);

    // Counter can hold WIDTH itself, so it never wraps inside a frame.
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

`ifdef SERIAL_TX_PARITY_EN
    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StShift  = 2'b01,
        StDone   = 2'b10,
        StParity = 2'b11
    } state_e;
`else
    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StShift = 2'b01,
        StDone  = 2'b10
    } state_e;
`endif

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               beat;
    logic               out_bit;
    logic               cnt_is_first;
    logic               cnt_is_last;

`ifdef SERIAL_TX_PARITY_EN
    logic               par_q, par_d;
`endif

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q <= StIdle;
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef SERIAL_TX_PARITY_EN
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

    // The bit at the output end of the shift register is the current bit.
    assign out_bit      = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    assign cnt_is_first = (cnt_q == '0);
    assign cnt_is_last  = (cnt_q == CNT_LAST);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
`ifdef SERIAL_TX_PARITY_EN
        par_d   = par_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    shreg_d = in_data;
                    cnt_d   = '0;
`ifdef SERIAL_TX_PARITY_EN
                    par_d   = ^in_data;
`endif
                    state_d = StShift;
                end
            end

            StShift: begin
                if (sout_ready) begin
                    // Shift toward the output end with zero fill.
                    shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_is_last) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StDone;
`endif
                    end
                end
            end

`ifdef SERIAL_TX_PARITY_EN
            StParity: begin
                if (sout_ready) begin
                    state_d = StDone;
                end
            end
`endif

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    always_comb begin
        in_ready   = 1'b0;
        sout       = 1'b0;
        sout_valid = 1'b0;
        sof        = 1'b0;
        eof        = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
            end

            StShift: begin
                sout_valid = 1'b1;
                busy       = 1'b1;
                sout       = out_bit;
                sof        = cnt_is_first;
`ifdef SERIAL_TX_PARITY_EN
                eof        = 1'b0;
`else
                eof        = cnt_is_last;
`endif
            end

`ifdef SERIAL_TX_PARITY_EN
            StParity: begin
                sout_valid = 1'b1;
                busy       = 1'b1;
                sout       = par_q;
                eof        = 1'b1;
            end
`endif

            StDone: begin
                done = 1'b1;
            end

            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    assign beat = sout_valid & sout_ready;

    // beat is kept as a named handshake term for waveform readability only.
    logic unused_beat;
    assign unused_beat = beat;

endmodule

// File: tb/tb_bit_serial_operand_tx.sv
// Directed bench for bit_serial_operand_tx. Four instances share clock and
// reset: WIDTH=8 LSB-first, WIDTH=8 MSB-first, WIDTH=256 LSB-first and
// WIDTH=1. Inputs are driven and outputs sampled on the falling clock edge.
module tb_bit_serial_operand_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic [3:0]   iv;
    logic [3:0]   sr;
    logic [7:0]   d0;
    logic [7:0]   d1;
    logic [255:0] d2;
    logic [0:0]   d3;

    logic [3:0] o_ready, o_sout, o_valid, o_sof, o_eof, o_busy, o_done;

    int errors = 0;
    int checks = 0;

    bit_serial_operand_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) u_l8 (
        .clk(clk), .resetn(rst), .in_valid(iv[0]), .in_ready(o_ready[0]), .in_data(d0),
        .sout(o_sout[0]), .sout_valid(o_valid[0]), .sout_ready(sr[0]), .sof(o_sof[0]),
        .eof(o_eof[0]), .busy(o_busy[0]), .done(o_done[0])
    );

    bit_serial_operand_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_m8 (
        .clk(clk), .resetn(rst), .in_valid(iv[1]), .in_ready(o_ready[1]), .in_data(d1),
        .sout(o_sout[1]), .sout_valid(o_valid[1]), .sout_ready(sr[1]), .sof(o_sof[1]),
        .eof(o_eof[1]), .busy(o_busy[1]), .done(o_done[1])
    );

    bit_serial_operand_tx #(.WIDTH(256), .MSB_FIRST(1'b0)) u_l256 (
        .clk(clk), .resetn(rst), .in_valid(iv[2]), .in_ready(o_ready[2]), .in_data(d2),
        .sout(o_sout[2]), .sout_valid(o_valid[2]), .sout_ready(sr[2]), .sof(o_sof[2]),
        .eof(o_eof[2]), .busy(o_busy[2]), .done(o_done[2])
    );

    bit_serial_operand_tx #(.WIDTH(1), .MSB_FIRST(1'b0)) u_l1 (
        .clk(clk), .resetn(rst), .in_valid(iv[3]), .in_ready(o_ready[3]), .in_data(d3),
        .sout(o_sout[3]), .sout_valid(o_valid[3]), .sout_ready(sr[3]), .sof(o_sof[3]),
        .eof(o_eof[3]), .busy(o_busy[3]), .done(o_done[3])
    );

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input int sel, input string tag);
        check($sformatf("%s u%0d in_ready", tag, sel), 256'(o_ready[sel]), 256'd1);
        check($sformatf("%s u%0d sout_valid", tag, sel), 256'(o_valid[sel]), 256'd0);
        check($sformatf("%s u%0d sout", tag, sel), 256'(o_sout[sel]), 256'd0);
        check($sformatf("%s u%0d sof", tag, sel), 256'(o_sof[sel]), 256'd0);
        check($sformatf("%s u%0d eof", tag, sel), 256'(o_eof[sel]), 256'd0);
        check($sformatf("%s u%0d busy", tag, sel), 256'(o_busy[sel]), 256'd0);
        check($sformatf("%s u%0d done", tag, sel), 256'(o_done[sel]), 256'd0);
    endtask

    // Sends one word on instance sel. bp=1 alternates sout_ready 0,1,0,1...
    // abort_at >= 0 returns (still mid-frame) once that many bits were accepted.
    task automatic send(input int sel, input logic [255:0] word, input int width,
                        input bit msb, input bit bp, input int abort_at);
        int           i;
        int           cyc;
        int           beats;
        bit           r;
        logic         expb;
        logic [255:0] got;
        beats = width;
`ifdef SERIAL_TX_PARITY_EN
        beats = width + 1;
`endif
        @(negedge clk);
        case (sel)
            0: d0 = word[7:0];
            1: d1 = word[7:0];
            2: d2 = word;
            default: d3 = word[0:0];
        endcase
        iv[sel] = 1'b1;
        @(negedge clk);
        iv[sel] = 1'b0;
        i   = 0;
        cyc = 0;
        got = '0;
        r   = bp ? 1'b0 : 1'b1;
        while (i < beats && cyc < 4 * beats + 10 && !(abort_at >= 0 && i == abort_at)) begin
            if (i < width) expb = msb ? word[width-1-i] : word[i];
            else           expb = ^word;
            check($sformatf("u%0d b%0d sout", sel, i), 256'(o_sout[sel]), 256'(expb));
            check($sformatf("u%0d b%0d valid", sel, i), 256'(o_valid[sel]), 256'd1);
            check($sformatf("u%0d b%0d busy", sel, i), 256'(o_busy[sel]), 256'd1);
            check($sformatf("u%0d b%0d ready", sel, i), 256'(o_ready[sel]), 256'd0);
            check($sformatf("u%0d b%0d sof", sel, i), 256'(o_sof[sel]), 256'(i == 0));
            check($sformatf("u%0d b%0d eof", sel, i), 256'(o_eof[sel]), 256'(i == beats - 1));
            check($sformatf("u%0d b%0d done", sel, i), 256'(o_done[sel]), 256'd0);
            if (r && i < width) got[msb ? width - 1 - i : i] = o_sout[sel];
            sr[sel] = r;
            @(negedge clk);
            cyc++;
            if (r) i++;
            if (bp) r = ~r;
        end
        sr[sel] = 1'b1;
        if (abort_at >= 0) begin
            check($sformatf("u%0d abort point", sel), 256'(i), 256'(abort_at));
        end else begin
            check($sformatf("u%0d frame cycles", sel), 256'(cyc), 256'(bp ? 2 * beats : beats));
            check($sformatf("u%0d word", sel), got, word);
            check($sformatf("u%0d done pulse", sel), 256'(o_done[sel]), 256'd1);
            check($sformatf("u%0d done valid", sel), 256'(o_valid[sel]), 256'd0);
            check($sformatf("u%0d done sout", sel), 256'(o_sout[sel]), 256'd0);
            check($sformatf("u%0d done busy", sel), 256'(o_busy[sel]), 256'd0);
            check($sformatf("u%0d done ready", sel), 256'(o_ready[sel]), 256'd0);
            @(negedge clk);
            check_idle(sel, "after frame");
        end
    endtask

    initial begin
        rst = 1'b1;
        iv  = '0;
        sr  = '1;
        d0  = '0;
        d1  = '0;
        d2  = '0;
        d3  = '0;

        // Reset held for three cycles, then released.
        repeat (3) @(negedge clk);
        for (int s = 0; s < 4; s++) check_idle(s, "in reset");
        rst = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 4; s++) check_idle(s, "post reset");

        // LSB first, MSB first, MSB first with a single set LSB.
        send(0, 256'hA5, 8, 1'b0, 1'b0, -1);
        send(1, 256'hA5, 8, 1'b1, 1'b0, -1);
        send(1, 256'h01, 8, 1'b1, 1'b0, -1);

        // Backpressure: sout_ready alternates, each bit held until taken.
        send(0, 256'h3C, 8, 1'b0, 1'b1, -1);

        // WIDTH=1: sof and eof together on the single data bit.
        send(3, 256'h1, 1, 1'b0, 1'b0, -1);
        send(3, 256'h0, 1, 1'b0, 1'b1, -1);

        // Full-width frame, then a frame aborted by reset after 100 bits.
        send(2, {8{32'hDEADBEEF}}, 256, 1'b0, 1'b0, -1);
        send(2, {4{64'h0123_4567_89AB_CDEF}}, 256, 1'b0, 1'b0, 100);
        rst = 1'b1;
        #1;
        check_idle(2, "async abort");
        repeat (2) begin
            @(negedge clk);
            check("abort no done", 256'(o_done[2]), 256'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("abort no done after release", 256'(o_done[2]), 256'd0);
        check_idle(2, "after abort");
        send(2, 256'h1, 256, 1'b0, 1'b0, -1);

`ifdef SERIAL_TX_PARITY_EN
        // Appended parity: 8'h07 has odd weight, 8'h03 even.
        send(0, 256'h07, 8, 1'b0, 1'b0, -1);
        send(0, 256'h03, 8, 1'b0, 1'b0, -1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
